mux_scan_ctrl: RTL

Upstream sequencer for the 3-input `multiplexer` block. On request, it steps `sel` through channels 0, 1 and 2, holds each channel for a programmable settle time, and samples the mux output `dout` once per channel. It then presents the three sampled bits as one parallel word with a single-cycle valid pulse. It is the only driver of the mux select lines; select code 2'b11 is never issued.

---
 rtl/mux_scan_ctrl_if.sv | 28 ++
 rtl/mux_scan_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl_if.sv
// Handshake bundle between the scan controller and its requester/mux side.
// slave = controller, master = requester plus the mux output feeding mux_in.
interface mux_scan_ctrl_if;
  logic       start;
  logic       mux_in;
  logic [1:0] sel;
  logic       busy;
  logic [2:0] data;
  logic       valid;

  modport master (
    output start,
    output mux_in,
    input  sel,
    input  busy,
    input  data,
    input  valid
  );

  modport slave (
    input  start,
    input  mux_in,
    output sel,
    output busy,
    output data,
    output valid
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scans the 3-input mux channel by channel with a programmable dwell and reports one parallel word.
// Optional macro MUX_SCAN_CONT_EN: restart a scan at completion when start is high (no idle gap).
module mux_scan_ctrl #(
  parameter int DWELL = 4
) (
  input logic           clk,
  input logic           rst_n,
  mux_scan_ctrl_if.slave bus
);

  localparam int              CW       = ($clog2(DWELL) < 1) ? 1 : $clog2(DWELL);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t        state;
  logic [1:0]    ch;
  logic [CW-1:0] cnt;
  logic [2:0]    shadow;
  logic [1:0]    sel_r;
  logic          busy_r;
  logic [2:0]    data_r;
  logic          valid_r;

  logic dwell_done;
  logic last_ch;
  logic restart;

  assign dwell_done = (cnt == CNT_LAST);
  assign last_ch    = (ch == 2'd2);

`ifdef MUX_SCAN_CONT_EN
  assign restart = bus.start;
`else
  assign restart = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ch      <= 2'd0;
      cnt     <= '0;
      shadow  <= 3'b000;
      sel_r   <= 2'd0;
      busy_r  <= 1'b0;
      data_r  <= 3'b000;
      valid_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          sel_r <= 2'd0;
          ch    <= 2'd0;
          cnt   <= '0;
          if (bus.start) begin
            state  <= SCAN;
            busy_r <= 1'b1;
          end
        end

        SCAN: begin
          if (!dwell_done) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt        <= '0;
            shadow[ch] <= bus.mux_in;
            if (!last_ch) begin
              ch    <= ch + 2'd1;
              sel_r <= ch + 2'd1;
            end else begin
              // Channel 2 is taken straight from mux_in so data updates in one atomic write.
              data_r  <= {bus.mux_in, shadow[1], shadow[0]};
              valid_r <= 1'b1;
              ch      <= 2'd0;
              sel_r   <= 2'd0;
              if (!restart) begin
                state  <= IDLE;
                busy_r <= 1'b0;
              end
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          sel_r  <= 2'd0;
        end
      endcase
    end
  end

  assign bus.sel   = sel_r;
  assign bus.busy  = busy_r;
  assign bus.data  = data_r;
  assign bus.valid = valid_r;

endmodule
